perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised Avalon-MM slave holding NUM_CH independent performance counters of CNT_W bits each. It succeeds the single 64-bit cycle counter and adds the following:
- per-channel enable, clear and mode (clock cycles or external event pulses);
- a coherent hi/lo read through a snapshot register;
- a sticky overflow flag.

It attaches to the Nios II system as a 32-bit slave, and software uses it to time code regions (e.g. the 1000-multiplication benchmark) and count events.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
CNT_W, 64, counter width in bits (33..64); the hi word returns bits CNT_W-1:32, zero-extended
ADDR_W, 4, word-address width; must be >= clog2(NUM_CH)+2
RESET_EN, 'b0001, per-channel enable value after reset (channel 0 counts cycles from reset by default)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  word address: {channel, reg[1:0]}
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
writedata  in  32  write data
readdata  out  32  read data, fixed latency 1
event_in  in  NUM_CH  per-channel event inputs, synchronous to clk, level counted per cycle

Behaviour:
- Register map per channel ch, word offsets:
  - 0 LO: read returns cnt[31:0] and, in the same cycle, loads snap_hi <= cnt[CNT_W-1:32].
  - 1 HI: read returns snap_hi (zero-extended), not the live count.
  - 2 CTRL: bit0 EN (R/W), bit1 MODE (R/W; 0 = cycles, 1 = events), bit2 CLR (write-1 pulse, reads 0); other bits read 0.
  - 3 STAT: bit0 OVF (sticky; write 1 clears).
- Reset (reset=1 at a clk edge):
  - all cnt = 0, snap_hi = 0, OVF = 0, MODE = 0, EN[ch] = RESET_EN[ch];
  - readdata = 0.
  - Reset asserted mid-operation overrides any simultaneous read or write.
- Increment: when EN is set, cnt increments by 1 each cycle if MODE=0, or each cycle event_in[ch]=1 if MODE=1.
- Wrap: cnt = 2^CNT_W-1 followed by an increment gives cnt = 0 and sets OVF in that same edge.
- CLR write: cnt = 0 at that edge. Clear wins over a simultaneous increment. OVF is unaffected. The EN/MODE values written in the same word take effect from the next cycle.
- A STAT write of 1 and an overflow in the same cycle: OVF stays 1 (set wins).
- Read latency: readdata is registered and valid the cycle after read=1. In cycles after read=0, readdata = 0.
- A LO read returns the value present before that edge's increment. snap_hi is captured from the same pre-increment value, so a LO-then-HI sequence is atomic.
- Simultaneous read and write to the same register: read returns the pre-write value, and write side effects apply.
- Out-of-range channel (ch >= NUM_CH): reads return 0, writes are ignored.
- Writes to LO/HI are ignored. Read to an undefined bit returns 0.

Decomposition:
- Package perf_counter_pkg holds:
  - register offset constants REG_LO=0, REG_HI=1, REG_CTRL=2, REG_STAT=3;
  - CTRL bit positions;
  - typedef ctrl_t (packed struct: en, mode).
- One sub-module, perf_counter_ch: one channel's cnt, snap_hi, ctrl and OVF, with inc/clr/snap/ovf_clr inputs.
- The top level generates NUM_CH instances, decodes address, and muxes readdata.

Test Plan:
- Reset release, idle 10 cycles, read ch0 LO → readdata = 10 ± fixed offset (check the exact expected count); ch1 LO → 0 (RESET_EN=0001).
- CNT_W=40: force ch0 near wrap via CLR then run, and separately confirm wrap: set cnt to 2^40-2 (bench backdoor), 2 cycles → cnt = 0, STAT reads 1; write STAT=1 → STAT reads 0.
- ch0 cnt = 0x0000_0001_FFFF_FFFF at LO read → LO returns 0xFFFFFFFF; HI read 5 cycles later returns 0x00000001, not 0x00000002.
- ch2 CTRL write 0x3 (EN, MODE=event), drive event_in[2] high for 7 non-consecutive cycles → LO = 7; ch0 keeps counting cycles.
- ch1 CTRL write 0x5 (EN + CLR) while counting → next LO read = cycles since write minus 1; CLR coincident with increment yields 0 at that edge.
- Read address ch=5 on NUM_CH=4 → readdata = 0; write there → no channel state changes. Assert reset mid-count → all LO/HI/STAT = 0, readdata = 0.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Shared register-map constants and control types for the performance counter bank.
package perf_counter_pkg;

  localparam logic [1:0] REG_LO   = 2'd0;
  localparam logic [1:0] REG_HI   = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_CLR_BIT  = 2;
  localparam int STAT_OVF_BIT  = 0;

  typedef struct packed {
    logic mode;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Avalon-MM slave bus of the performance counter bank.
interface perf_counter_bank_if #(
  parameter int ADDR_W = 4
);
  // read/write are single-cycle strobes with no waitrequest: every strobe is
  // accepted at the edge it is sampled, and readdata is valid exactly one
  // cycle after read, reading 0 in any cycle that follows read=0.
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/perf_counter_ch.sv
// One counter channel: live count, hi-word snapshot, enable/mode and sticky overflow.
module perf_counter_ch
  import perf_counter_pkg::*;
#(
  parameter int CNT_W  = 64,
  parameter bit RST_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic              snap_i,
  input  logic              ovf_clr_i,
  input  logic              ctrl_we_i,
  input  ctrl_t             ctrl_wdata_i,
  output logic [31:0]       cnt_lo_o,
  output logic [CNT_W-33:0] snap_hi_o,
  output ctrl_t             ctrl_o,
  output logic              ovf_o
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]  snap_q, snap_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d;
  logic             wrap;

  // A clear suppresses the increment, so it also suppresses the wrap.
  assign wrap = inc_i && !clr_i && (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    snap_d = snap_i ? cnt_q[CNT_W-1:32] : snap_q;
    ctrl_d = ctrl_we_i ? ctrl_wdata_i : ctrl_q;

    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ctrl_q <= '{mode: 1'b0, en: RST_EN};
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_lo_o  = cnt_q[31:0];
  assign snap_hi_o = snap_q;
  assign ctrl_o    = ctrl_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters behind a 32-bit Avalon-MM slave.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 64,
  parameter int          ADDR_W   = 4,
  parameter logic [15:0] RESET_EN = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  perf_counter_bank_if.slave bus,
  input  logic [NUM_CH-1:0] event_in
);

  localparam int CH_W = ADDR_W - 2;
  localparam int HI_W = CNT_W - 32;

  logic [CH_W-1:0]   ch_sel;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] hit;
  logic [31:0]       cnt_lo  [NUM_CH];
  logic [HI_W-1:0]   snap_hi [NUM_CH];
  ctrl_t             ctrl    [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  ctrl_t             ctrl_wdata;
  logic [31:0]       rdata_d, rdata_q;

  assign ch_sel     = bus.address[ADDR_W-1:2];
  assign reg_sel    = bus.address[1:0];
  assign ctrl_wdata = '{mode: bus.writedata[CTRL_MODE_BIT], en: bus.writedata[CTRL_EN_BIT]};

  // Channels at or above NUM_CH never get a hit, so they read 0 and ignore writes.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic inc, wr_ctrl, wr_stat;

    assign hit[i]  = (ch_sel == CH_W'(i));
    assign wr_ctrl = bus.write && hit[i] && (reg_sel == REG_CTRL);
    assign wr_stat = bus.write && hit[i] && (reg_sel == REG_STAT);
    assign inc     = ctrl[i].en && (!ctrl[i].mode || event_in[i]);

    perf_counter_ch #(
      .CNT_W  (CNT_W),
      .RST_EN (RESET_EN[i])
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .inc_i        (inc),
      .clr_i        (wr_ctrl && bus.writedata[CTRL_CLR_BIT]),
      .snap_i       (bus.read && hit[i] && (reg_sel == REG_LO)),
      .ovf_clr_i    (wr_stat && bus.writedata[STAT_OVF_BIT]),
      .ctrl_we_i    (wr_ctrl),
      .ctrl_wdata_i (ctrl_wdata),
      .cnt_lo_o     (cnt_lo[i]),
      .snap_hi_o    (snap_hi[i]),
      .ctrl_o       (ctrl[i]),
      .ovf_o        (ovf[i])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.read && hit[i]) begin
        case (reg_sel)
          REG_LO:   rdata_d = cnt_lo[i];
          REG_HI:   rdata_d = 32'(snap_hi[i]);
          REG_CTRL: rdata_d = {30'b0, ctrl[i].mode, ctrl[i].en};
          REG_STAT: rdata_d = {31'b0, ovf[i]};
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with hand-computed expected register values.
module tb_perf_counter_bank;
  import perf_counter_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 40;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] event_in = '0;
  int                checks = 0;
  int                failures = 0;
  int unsigned       cyc = 0;
  logic [31:0]       rd;
  logic [31:0]       exp_v;

  perf_counter_bank_if #(.ADDR_W(ADDR_W)) bus_if ();

  perf_counter_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .ADDR_W   (ADDR_W),
    .RESET_EN (16'h0001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .event_in (event_in)
  );

  // clock / reset-relative cycle model (channel 0 counts every cycle out of reset)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: called between edges, each consumes exactly one active edge
  task automatic bus_read(input int ch, input logic [1:0] rg, output logic [31:0] data);
    bus_if.address = {ch[ADDR_W-3:0], rg};
    bus_if.read    = 1'b1;
    @(posedge clk);
    #1;
    data = bus_if.readdata;
    @(negedge clk);
    bus_if.read = 1'b0;
  endtask

  task automatic bus_write(input int ch, input logic [1:0] rg, input logic [31:0] data);
    bus_if.address   = {ch[ADDR_W-3:0], rg};
    bus_if.writedata = data;
    bus_if.write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.write = 1'b0;
  endtask

  initial begin
    bus_if.address   = '0;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdata", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // channel 0 counts cycles from reset, channel 1 idle
    repeat (10) @(negedge clk);
    bus_read(0, REG_LO, rd);   check_eq("ch0_lo_10", rd, 32'd10);
    bus_read(1, REG_LO, rd);   check_eq("ch1_lo_0", rd, 32'd0);
    bus_read(0, REG_HI, rd);   check_eq("ch0_hi_0", rd, 32'd0);
    bus_read(0, REG_CTRL, rd); check_eq("ch0_ctrl", rd, 32'h1);
    @(posedge clk);
    #1;
    check_eq("rdata_idle", bus_if.readdata, 32'h0);
    @(negedge clk);

    // ch2 event mode; event on the enabling edge itself must not count
    event_in[2] = 1'b1;
    bus_write(2, REG_CTRL, 32'h3);
    for (int k = 0; k < 7; k++) begin
      event_in[2] = 1'b1;
      @(negedge clk);
      event_in[2] = 1'b0;
      @(negedge clk);
    end
    bus_read(2, REG_LO, rd);   check_eq("ch2_events", rd, 32'd7);
    bus_read(2, REG_CTRL, rd); check_eq("ch2_ctrl", rd, 32'h3);
    exp_v = cyc;
    bus_read(0, REG_LO, rd);   check_eq("ch0_cycles", rd, exp_v);

    // ch1 enable, then EN+CLR while counting
    bus_write(1, REG_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(1, REG_CTRL, 32'h5);
    bus_read(1, REG_LO, rd);   check_eq("ch1_clr_edge", rd, 32'd0);
    repeat (3) @(negedge clk);
    bus_read(1, REG_LO, rd);   check_eq("ch1_after_clr", rd, 32'd4);
    bus_read(1, REG_CTRL, rd); check_eq("ch1_ctrl_clr0", rd, 32'h1);

    // simultaneous read and write of ch3 CTRL; undefined bits read 0
    bus_if.address   = {3'd3, REG_CTRL};
    bus_if.writedata = 32'hFFFF_FFF9;
    bus_if.read      = 1'b1;
    bus_if.write     = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ch3_rw_old", bus_if.readdata, 32'h0);
    @(negedge clk);
    bus_if.read  = 1'b0;
    bus_if.write = 1'b0;
    bus_read(3, REG_CTRL, rd); check_eq("ch3_rw_new", rd, 32'h1);

    // out-of-range channel 5
    bus_read(5, REG_LO, rd);   check_eq("ch5_lo", rd, 32'h0);
    bus_read(5, REG_CTRL, rd); check_eq("ch5_ctrl", rd, 32'h0);
    bus_write(5, REG_CTRL, 32'h4);
    bus_read(1, REG_CTRL, rd); check_eq("ch5_wr_ch1_ctrl", rd, 32'h1);
    bus_read(2, REG_LO, rd);   check_eq("ch5_wr_ch2_lo", rd, 32'd7);

    // atomic hi/lo snapshot
    force dut.g_ch[0].u_ch.cnt_q = 40'h01_FFFF_FFFF;
    #1;
    release dut.g_ch[0].u_ch.cnt_q;
    bus_read(0, REG_LO, rd);   check_eq("snap_lo", rd, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    bus_read(0, REG_HI, rd);   check_eq("snap_hi", rd, 32'h1);

    // wrap at 2^40 and sticky overflow
    force dut.g_ch[0].u_ch.cnt_q = 40'hFF_FFFF_FFFE;
    #1;
    release dut.g_ch[0].u_ch.cnt_q;
    bus_read(0, REG_STAT, rd); check_eq("ovf_pre_wrap", rd, 32'h0);
    @(negedge clk);
    bus_read(0, REG_LO, rd);   check_eq("wrap_lo", rd, 32'h0);
    bus_read(0, REG_STAT, rd); check_eq("ovf_set", rd, 32'h1);
    bus_read(0, REG_HI, rd);   check_eq("wrap_hi", rd, 32'h0);
    bus_write(0, REG_CTRL, 32'h5);
    bus_read(0, REG_STAT, rd); check_eq("ovf_after_clr", rd, 32'h1);
    bus_write(0, REG_STAT, 32'h0);
    bus_read(0, REG_STAT, rd); check_eq("ovf_wr0", rd, 32'h1);
    bus_write(0, REG_STAT, 32'h1);
    bus_read(0, REG_STAT, rd); check_eq("ovf_wr1", rd, 32'h0);
    force dut.g_ch[0].u_ch.cnt_q = 40'hFF_FFFF_FFFF;
    #1;
    release dut.g_ch[0].u_ch.cnt_q;
    bus_write(0, REG_STAT, 32'h1);
    bus_read(0, REG_STAT, rd); check_eq("ovf_set_wins", rd, 32'h1);
    force dut.g_ch[0].u_ch.cnt_q = 40'h12_3456_789A;
    #1;
    release dut.g_ch[0].u_ch.cnt_q;
    bus_read(0, REG_LO, rd);   check_eq("pre_rst_lo", rd, 32'h3456_789A);
    bus_read(0, REG_HI, rd);   check_eq("pre_rst_hi", rd, 32'h12);

    // reset mid-operation overrides a simultaneous read
    reset          = 1'b1;
    bus_if.address = {3'd0, REG_LO};
    bus_if.read    = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_rdata", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset       = 1'b0;
    bus_if.read = 1'b0;
    bus_read(0, REG_HI, rd);   check_eq("rst_ch0_hi", rd, 32'h0);
    bus_read(0, REG_STAT, rd); check_eq("rst_ch0_stat", rd, 32'h0);
    bus_read(0, REG_CTRL, rd); check_eq("rst_ch0_ctrl", rd, 32'h1);
    bus_read(2, REG_LO, rd);   check_eq("rst_ch2_lo", rd, 32'h0);
    bus_read(2, REG_CTRL, rd); check_eq("rst_ch2_ctrl", rd, 32'h0);
    bus_read(1, REG_LO, rd);   check_eq("rst_ch1_lo", rd, 32'h0);
    bus_read(3, REG_CTRL, rd); check_eq("rst_ch3_ctrl", rd, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
